// File: rtl/setting_mode_parser_pkg.sv
// setting_mode_parser_pkg: state encodings, error codes and ASCII constants for the settings parser.
package setting_mode_parser_pkg;
  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_WAIT_BYTE = 4'd1,
    S_CHECK     = 4'd2,
    S_SEND      = 4'd3,
    S_TX_WAIT   = 4'd4,
    S_COMMIT    = 4'd5,
    S_DONE      = 4'd6
  } state_e;
  localparam logic [3:0] ERR_NONE    = 4'd0;
  localparam logic [3:0] ERR_CHAR    = 4'd1;
  localparam logic [3:0] ERR_RANGE   = 4'd2;
  localparam logic [3:0] ERR_TIMEOUT = 4'd3;
  localparam logic [7:0] ASCII_E   = 8'h45;
  localparam logic [7:0] ASCII_DOT = 8'h2E;
  localparam logic [7:0] ASCII_S   = 8'h53;
  localparam logic [7:0] ASCII_T   = 8'h54;
  localparam logic [7:0] ASCII_SP  = 8'h20;
  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] ASCII_LF  = 8'h0A;
  localparam logic [7:0] ASCII_0   = 8'h30;
  localparam logic [7:0] ASCII_9   = 8'h39;
  function automatic logic is_term(input logic [7:0] b);
    return b == ASCII_SP || b == ASCII_CR || b == ASCII_LF;
  endfunction
endpackage

// File: rtl/setting_mode_parser_accum.sv
// cfg_digit_accum: saturating decimal accumulator with digit count and overflow flag.
module cfg_digit_accum #(
  parameter int FIELD_WIDTH = 4,
  parameter int MAX_DIGITS  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr_i,
  input  logic                   digit_valid_i,
  input  logic [3:0]             digit_i,
  output logic [FIELD_WIDTH-1:0] acc_o,
  output logic                   has_digit_o,
  output logic                   ovf_o
);
  localparam int WW = FIELD_WIDTH + 4;
  localparam int CW = $clog2(MAX_DIGITS + 2);
  logic [FIELD_WIDTH-1:0] acc_q;
  logic [CW-1:0]          cnt_q;
  logic                   ovf_q;
  logic [WW-1:0]          prod;
  logic                   big, cnt_full;
  always_comb begin
    prod     = {4'b0, acc_q} * WW'(10) + WW'(digit_i);
    big      = |prod[WW-1:FIELD_WIDTH];
    cnt_full = cnt_q >= CW'(MAX_DIGITS);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (clr_i) begin
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (digit_valid_i) begin
      acc_q <= big ? '1 : prod[FIELD_WIDTH-1:0];
      cnt_q <= cnt_full ? cnt_q : cnt_q + CW'(1);
      ovf_q <= ovf_q | big | cnt_full;
    end
  end
  assign acc_o       = acc_q;
  assign has_digit_o = |cnt_q;
  assign ovf_o       = ovf_q;
endmodule

// File: rtl/setting_mode_parser.sv
// setting_mode_parser: parses decimal ASCII fields from UART RX into range-checked config registers,
// acknowledging each field and committing all fields atomically.
module setting_mode_parser
  import setting_mode_parser_pkg::*;
#(
  parameter int NUM_FIELDS     = 3,
  parameter int FIELD_WIDTH    = 4,
  parameter int MAX_DIGITS     = 2,
  parameter logic [NUM_FIELDS*FIELD_WIDTH-1:0] FIELD_MIN     = {4'd1, 4'd0, 4'd1},
  parameter logic [NUM_FIELDS*FIELD_WIDTH-1:0] FIELD_MAX     = {4'd10, 4'd9, 4'd5},
  parameter logic [NUM_FIELDS*FIELD_WIDTH-1:0] FIELD_DEFAULT = {4'd2, 4'd9, 4'd5},
  parameter int TIMEOUT_CYCLES = 100000000
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              mode_active,
  input  logic [7:0]                        rx_data,
  input  logic                              rx_valid,
  output logic                              clear_rx_buffer,
  output logic [7:0]                        tx_data,
  output logic                              tx_start,
  input  logic                              tx_busy,
  output logic [NUM_FIELDS*FIELD_WIDTH-1:0] cfg_out,
  output logic                              cfg_update,
  output logic [3:0]                        error_code,
  output logic [3:0]                        sub_state
);
  localparam int IW = NUM_FIELDS > 1 ? $clog2(NUM_FIELDS) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  state_e                            state_q;
  logic [IW-1:0]                     idx_q;
  logic [NUM_FIELDS*FIELD_WIDTH-1:0] shadow_q, cfg_q;
  logic [3:0]                        err_q;
  logic [7:0]                        tx_data_q;
  logic                              tx_start_q, clr_q, upd_q;
  logic [TW-1:0]                     tmr_q;
  logic                              seen_busy_q, low_q, term_q;
  logic [FIELD_WIDTH-1:0]            acc, fmin, fmax;
  logic                              has_digit, ovf;
  logic                              take, is_digit, is_sep, acc_clr, in_range, last, tmo;
  always_comb begin
    take     = mode_active && rx_valid && state_q == S_WAIT_BYTE;
    is_digit = rx_data >= ASCII_0 && rx_data <= ASCII_9;
    is_sep   = is_term(rx_data);
    acc_clr  = !mode_active || state_q == S_IDLE || state_q == S_CHECK || (take && !is_digit && !is_sep);
    fmin     = FIELD_MIN[int'(idx_q)*FIELD_WIDTH +: FIELD_WIDTH];
    fmax     = FIELD_MAX[int'(idx_q)*FIELD_WIDTH +: FIELD_WIDTH];
    in_range = !ovf && acc >= fmin && acc <= fmax;
    last     = idx_q == IW'(NUM_FIELDS - 1);
    tmo      = tmr_q >= TW'(TIMEOUT_CYCLES - 1);
  end
  cfg_digit_accum #(.FIELD_WIDTH(FIELD_WIDTH), .MAX_DIGITS(MAX_DIGITS)) u_accum (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr_i        (acc_clr),
    .digit_valid_i(take && is_digit),
    .digit_i      (rx_data[3:0]),
    .acc_o        (acc),
    .has_digit_o  (has_digit),
    .ovf_o        (ovf)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      shadow_q    <= FIELD_DEFAULT;
      cfg_q       <= FIELD_DEFAULT;
      err_q       <= ERR_NONE;
      tx_data_q   <= '0;
      tx_start_q  <= 1'b0;
      clr_q       <= 1'b0;
      upd_q       <= 1'b0;
      tmr_q       <= '0;
      seen_busy_q <= 1'b0;
      low_q       <= 1'b0;
      term_q      <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      clr_q      <= 1'b0;
      upd_q      <= 1'b0;
      if (!mode_active) state_q <= S_IDLE;
      else case (state_q)
        S_IDLE: begin
          shadow_q <= cfg_q;
          idx_q    <= '0;
          err_q    <= ERR_NONE;
          term_q   <= 1'b0;
          tmr_q    <= '0;
          state_q  <= S_WAIT_BYTE;
        end
        S_WAIT_BYTE: begin
          if (rx_valid) begin
            clr_q <= 1'b1;
            tmr_q <= '0;
            if (is_sep) state_q <= S_CHECK;
            else if (!is_digit) begin
              err_q     <= ERR_CHAR;
              tx_data_q <= ASCII_E;
              state_q   <= S_SEND;
            end
          end else if (tmo) begin
            // Shadow is simply abandoned; the next activation reloads it from cfg_q.
            err_q     <= ERR_TIMEOUT;
            tx_data_q <= ASCII_T;
            term_q    <= 1'b1;
            tmr_q     <= '0;
            state_q   <= S_SEND;
          end else tmr_q <= tmr_q + TW'(1);
        end
        S_CHECK: begin
          if (has_digit && !in_range) begin
            err_q     <= ERR_RANGE;
            tx_data_q <= ASCII_E;
            state_q   <= S_SEND;
          end else begin
            if (has_digit) begin
              shadow_q[int'(idx_q)*FIELD_WIDTH +: FIELD_WIDTH] <= acc;
              err_q <= ERR_NONE;
            end
            if (last) state_q <= S_COMMIT;
            else begin
              idx_q     <= idx_q + IW'(1);
              tx_data_q <= ASCII_DOT;
              state_q   <= S_SEND;
            end
          end
        end
        S_SEND: if (!tx_busy) begin
          tx_start_q  <= 1'b1;
          seen_busy_q <= 1'b0;
          low_q       <= 1'b0;
          state_q     <= S_TX_WAIT;
        end
        S_TX_WAIT: begin
          if (tx_busy) seen_busy_q <= 1'b1;
          else if (seen_busy_q || low_q) state_q <= term_q ? S_DONE : S_WAIT_BYTE;
          else low_q <= 1'b1;
        end
        S_COMMIT: if (!tx_busy) begin
          cfg_q       <= shadow_q;
          upd_q       <= 1'b1;
          tx_data_q   <= ASCII_S;
          tx_start_q  <= 1'b1;
          term_q      <= 1'b1;
          seen_busy_q <= 1'b0;
          low_q       <= 1'b0;
          state_q     <= S_TX_WAIT;
        end
        S_DONE: state_q <= S_DONE;
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign clear_rx_buffer = clr_q;
  assign tx_data         = tx_data_q;
  assign tx_start        = tx_start_q;
  assign cfg_out         = cfg_q;
  assign cfg_update      = upd_q;
  assign error_code      = err_q;
  assign sub_state       = state_q;
endmodule

// File: tb/tb_setting_mode_parser.sv
// tb_setting_mode_parser: scoreboard bench for the settings parser (tx bytes and commits checked by a monitor).
module tb_setting_mode_parser;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mode_active = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        tx_busy = 1'b0;
  logic        clear_rx_buffer, tx_start, cfg_update;
  logic [7:0]  tx_data;
  logic [11:0] cfg_out;
  logic [3:0]  error_code, sub_state;
  int          checks = 0, failures = 0, upd_cnt = 0;
  logic [7:0]  exp_tx[$];
  logic [11:0] exp_cfg[$];
  logic [7:0]  mon_tx;
  logic [11:0] mon_cfg;

  localparam logic [11:0] DEF = {4'd2, 4'd9, 4'd5};

  setting_mode_parser #(.TIMEOUT_CYCLES(50)) dut (
    .clk(clk), .rst_n(rst_n), .mode_active(mode_active), .rx_data(rx_data), .rx_valid(rx_valid),
    .clear_rx_buffer(clear_rx_buffer), .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .cfg_out(cfg_out), .cfg_update(cfg_update), .error_code(error_code), .sub_state(sub_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  always @(negedge clk) if (rst_n) begin
    if (tx_start) begin
      checks++;
      if (exp_tx.size() == 0) begin
        failures++;
        $display("FAIL tx_unexpected got=%h expected none", tx_data);
      end else begin
        mon_tx = exp_tx.pop_front();
        if (tx_data !== mon_tx) begin
          failures++;
          $display("FAIL tx_byte got=%h expected=%h", tx_data, mon_tx);
        end
      end
    end
    if (cfg_update) begin
      upd_cnt++;
      checks++;
      if (exp_cfg.size() == 0) begin
        failures++;
        $display("FAIL cfg_update_unexpected cfg=%h", cfg_out);
      end else begin
        mon_cfg = exp_cfg.pop_front();
        if (cfg_out !== mon_cfg) begin
          failures++;
          $display("FAIL cfg_commit got=%h expected=%h", cfg_out, mon_cfg);
        end
      end
      checks++;
      if (!(tx_start === 1'b1 && tx_data === 8'h53)) begin
        failures++;
        $display("FAIL update_with_S tx_start=%b tx_data=%h expected 1/53", tx_start, tx_data);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; mode_active = 1'b0; rx_valid = 1'b0; tx_busy = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_state(input logic [3:0] s, input int budget);
    int n = 0;
    while (sub_state !== s && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sub_state !== s) begin
      checks++;
      failures++;
      $display("FAIL wait_state got=%0d expected=%0d", sub_state, s);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    wait_state(4'd1, 200);
    rx_data = b; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic end_session();
    @(negedge clk);
    mode_active = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks += 7;
    if (cfg_out !== DEF) begin failures++; $display("FAIL rst_cfg got=%h expected=%h", cfg_out, DEF); end
    if (cfg_update !== 1'b0) begin failures++; $display("FAIL rst_upd got=%b expected=0", cfg_update); end
    if (tx_start !== 1'b0) begin failures++; $display("FAIL rst_tx_start got=%b expected=0", tx_start); end
    if (clear_rx_buffer !== 1'b0) begin failures++; $display("FAIL rst_clr got=%b expected=0", clear_rx_buffer); end
    if (tx_data !== 8'h00) begin failures++; $display("FAIL rst_tx_data got=%h expected=00", tx_data); end
    if (error_code !== 4'd0) begin failures++; $display("FAIL rst_err got=%0d expected=0", error_code); end
    if (sub_state !== 4'd0) begin failures++; $display("FAIL rst_state got=%0d expected=0", sub_state); end
  endtask

  task automatic test_basic();
    int u0;
    do_reset();
    u0 = upd_cnt;
    mode_active = 1'b1;
    exp_tx.push_back(8'h2E); exp_tx.push_back(8'h2E); exp_tx.push_back(8'h53);
    exp_cfg.push_back({4'd4, 4'd7, 4'd3});
    wait_state(4'd1, 20);
    rx_data = "3"; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    checks++;
    if (clear_rx_buffer !== 1'b1) begin failures++; $display("FAIL clr_pulse got=%b expected=1", clear_rx_buffer); end
    send_str(" 7 4\r");
    wait_state(4'd6, 200);
    checks += 3;
    if (cfg_out !== {4'd4, 4'd7, 4'd3}) begin failures++; $display("FAIL basic_cfg got=%h expected=473", cfg_out); end
    if (upd_cnt - u0 !== 1) begin failures++; $display("FAIL basic_upd_count got=%0d expected=1", upd_cnt - u0); end
    if (error_code !== 4'd0) begin failures++; $display("FAIL basic_err got=%0d expected=0", error_code); end
    rx_data = "5"; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    checks += 2;
    if (clear_rx_buffer !== 1'b0) begin failures++; $display("FAIL drop_clr got=%b expected=0", clear_rx_buffer); end
    if (sub_state !== 4'd6) begin failures++; $display("FAIL done_hold got=%0d expected=6", sub_state); end
    end_session();
    checks++;
    if (sub_state !== 4'd0) begin failures++; $display("FAIL done_exit got=%0d expected=0", sub_state); end
  endtask

  task automatic test_range();
    do_reset();
    mode_active = 1'b1;
    exp_tx.push_back(8'h45);
    send_str("9 ");
    wait_state(4'd1, 200);
    checks += 2;
    if (error_code !== 4'd2) begin failures++; $display("FAIL range_err got=%0d expected=2", error_code); end
    if (cfg_out !== DEF) begin failures++; $display("FAIL range_no_leak got=%h expected=%h", cfg_out, DEF); end
    exp_tx.push_back(8'h2E); exp_tx.push_back(8'h2E); exp_tx.push_back(8'h53);
    exp_cfg.push_back({4'd1, 4'd2, 4'd4});
    send_str("4 2 1 ");
    wait_state(4'd6, 200);
    checks += 2;
    if (cfg_out !== {4'd1, 4'd2, 4'd4}) begin failures++; $display("FAIL retry_cfg got=%h expected=124", cfg_out); end
    if (error_code !== 4'd0) begin failures++; $display("FAIL retry_err got=%0d expected=0", error_code); end
    end_session();
  endtask

  task automatic test_char_ovf();
    do_reset();
    mode_active = 1'b1;
    exp_tx.push_back(8'h45);
    send_str("1x");
    wait_state(4'd1, 200);
    checks++;
    if (error_code !== 4'd1) begin failures++; $display("FAIL char_err got=%0d expected=1", error_code); end
    exp_tx.push_back(8'h45);
    send_str("123 ");
    wait_state(4'd1, 200);
    checks++;
    if (error_code !== 4'd2) begin failures++; $display("FAIL ovf_err got=%0d expected=2", error_code); end
    exp_tx.push_back(8'h2E);
    send_str("3 ");
    wait_state(4'd1, 200);
    checks++;
    if (error_code !== 4'd0) begin failures++; $display("FAIL after_ovf_err got=%0d expected=0", error_code); end
    end_session();
  endtask

  task automatic test_empty();
    do_reset();
    mode_active = 1'b1;
    exp_tx.push_back(8'h2E); exp_tx.push_back(8'h2E); exp_tx.push_back(8'h53);
    exp_cfg.push_back(DEF);
    send_str("  \r");
    wait_state(4'd6, 200);
    checks++;
    if (cfg_out !== DEF) begin failures++; $display("FAIL empty_cfg got=%h expected=%h", cfg_out, DEF); end
    end_session();
  endtask

  task automatic test_timeout();
    int u0;
    do_reset();
    u0 = upd_cnt;
    mode_active = 1'b1;
    exp_tx.push_back(8'h2E); exp_tx.push_back(8'h54);
    send_str("3 ");
    wait_state(4'd6, 300);
    checks += 3;
    if (error_code !== 4'd3) begin failures++; $display("FAIL tmo_err got=%0d expected=3", error_code); end
    if (cfg_out !== DEF) begin failures++; $display("FAIL tmo_cfg got=%h expected=%h", cfg_out, DEF); end
    if (upd_cnt !== u0) begin failures++; $display("FAIL tmo_upd got=%0d expected=%0d", upd_cnt, u0); end
    end_session();
  endtask

  task automatic test_busy_abort();
    int early = 0;
    int u0;
    do_reset();
    u0 = upd_cnt;
    mode_active = 1'b1;
    exp_tx.push_back(8'h2E);
    send_str("3 ");
    @(negedge clk);
    checks++;
    if (tx_start !== 1'b0) begin failures++; $display("FAIL latency_t1 got=%b expected=0", tx_start); end
    @(negedge clk);
    checks++;
    if (tx_start !== 1'b1) begin failures++; $display("FAIL latency_t2 got=%b expected=1", tx_start); end
    exp_tx.push_back(8'h2E);
    send_byte("7");
    tx_busy = 1'b1;
    send_byte(" ");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx_start !== 1'b0) early++;
    end
    tx_busy = 1'b0;
    checks++;
    if (early !== 0) begin failures++; $display("FAIL busy_hold got=%0d starts expected=0", early); end
    @(negedge clk);
    checks++;
    if (tx_start !== 1'b1) begin failures++; $display("FAIL busy_release got=%b expected=1", tx_start); end
    wait_state(4'd1, 50);
    mode_active = 1'b0;
    @(negedge clk);
    checks += 4;
    if (sub_state !== 4'd0) begin failures++; $display("FAIL abort_state got=%0d expected=0", sub_state); end
    if (cfg_update !== 1'b0) begin failures++; $display("FAIL abort_upd got=%b expected=0", cfg_update); end
    if (cfg_out !== DEF) begin failures++; $display("FAIL abort_cfg got=%h expected=%h", cfg_out, DEF); end
    if (upd_cnt !== u0) begin failures++; $display("FAIL abort_upd_count got=%0d expected=%0d", upd_cnt, u0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_range();
    test_char_ovf();
    test_empty();
    test_timeout();
    test_busy_abort();
    repeat (5) @(negedge clk);
    checks++;
    if (exp_tx.size() !== 0 || exp_cfg.size() !== 0) begin
      failures++;
      $display("FAIL scoreboard_drain tx_left=%0d cfg_left=%0d expected 0/0", exp_tx.size(), exp_cfg.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
